// File: rtl/rsa_pkg.sv
// Shared types for the RSA job scheduler: key width default, scheduler states
// and the requester id.
package rsa_pkg;

  localparam int KEY_W_DEF = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RESP
  } sched_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: when both request, the one not served last wins.
module rr_arbiter2
  import rsa_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    rr_last,
  output logic [1:0] grant,
  output req_id_t    grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~rr_last;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
    grant = 2'b00;
    if (|req) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one modular-exponentiation core between two requesters, with a
// run-time watchdog that aborts a hung core and returns a flagged result.
module rsa_job_scheduler
  import rsa_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               avm_clk,
  input  logic               avm_rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*KEY_W-1:0] req_msg,
  input  logic [2*KEY_W-1:0] req_key,
  input  logic [2*KEY_W-1:0] req_n,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [KEY_W-1:0]   rsp_data,
  output logic               rsp_timeout,
  output logic               core_start,
  output logic               core_abort,
  output logic [KEY_W-1:0]   core_msg,
  output logic [KEY_W-1:0]   core_key,
  output logic [KEY_W-1:0]   core_n,
  input  logic [KEY_W-1:0]   core_ans,
  input  logic               core_finished,
  output logic               busy,
  output req_id_t            grant_id
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  sched_state_t    state;
  req_id_t         rr_last;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      arb_grant;
  req_id_t         arb_idx;
  logic            wd_expire;

  rr_arbiter2 u_arb (
    .req       (req_valid),
    .rr_last   (rr_last),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Gated by reset so nothing is offered while the block is held in reset.
  assign req_ready  = (state == S_IDLE && !avm_rst) ? arb_grant : 2'b00;
  assign busy       = (state != S_IDLE);
  assign wd_expire  = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);
  // Decided in the expiry cycle itself so a coincident core_finished suppresses it.
  assign core_abort = (state == S_RUN) && wd_expire && !core_finished;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state       <= S_IDLE;
      rr_last     <= 1'b1;
      wd_cnt      <= '0;
      core_msg    <= '0;
      core_key    <= '0;
      core_n      <= '0;
      core_start  <= 1'b0;
      rsp_valid   <= 2'b00;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      grant_id    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|(req_valid & req_ready)) begin
            core_msg   <= arb_idx ? req_msg[2*KEY_W-1:KEY_W] : req_msg[KEY_W-1:0];
            core_key   <= arb_idx ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
            core_n     <= arb_idx ? req_n[2*KEY_W-1:KEY_W]   : req_n[KEY_W-1:0];
            grant_id   <= arb_idx;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (core_finished) begin
            rsp_data    <= core_ans;
            rsp_timeout <= 1'b0;
            rsp_valid   <= grant_id ? 2'b10 : 2'b01;
            state       <= S_RESP;
          end else if (wd_expire) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= grant_id ? 2'b10 : 2'b01;
            state       <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_id]) begin
            rr_last   <= grant_id;
            rsp_valid <= 2'b00;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Bench for rsa_job_scheduler: stub core, table-driven single jobs, directed
// corner sequences and a randomized transaction-level comparison.
`timescale 1ns/1ps
module tb_rsa_job_scheduler;

  localparam int KW = 16;

  logic            avm_clk = 1'b0;
  logic            avm_rst = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [2*KW-1:0] req_msg = '0, req_key = '0, req_n = '0;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = 2'b00;
  logic [KW-1:0]   rsp_data;
  logic            rsp_timeout, core_start, core_abort, core_finished, busy, grant_id;
  logic [KW-1:0]   core_msg, core_key, core_n, core_ans;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  rsa_job_scheduler #(.KEY_W(KW), .TIMEOUT_CYC(50)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_key(req_key), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .core_start(core_start), .core_abort(core_abort),
    .core_msg(core_msg), .core_key(core_key), .core_n(core_n),
    .core_ans(core_ans), .core_finished(core_finished),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 avm_clk = ~avm_clk;
  always @(posedge avm_clk) cyc++;

  function automatic logic [KW-1:0] modexp(input logic [KW-1:0] b, input logic [KW-1:0] e,
                                           input logic [KW-1:0] n);
    longint r, x;
    if (n < 2) return '0;
    r = 1;
    x = longint'(b) % longint'(n);
    for (int i = 0; i < KW; i++) begin
      if (e[i]) r = (r * x) % longint'(n);
      x = (x * x) % longint'(n);
    end
    return KW'(r);
  endfunction

  // Stub core: finishes stub_lat cycles after core_start (0 = never).
  int            stub_lat = 0;
  bit            rand_lat = 0;
  bit            man_fin = 0;
  int            down;
  logic [KW-1:0] stub_ans;
  always @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      down     <= 0;
      stub_ans <= '0;
    end else if (core_start) begin
      down     <= rand_lat ? int'($urandom_range(1, 20)) : stub_lat;
      stub_ans <= modexp(core_msg, core_key, core_n);
    end else if (core_abort) begin
      down <= 0;
    end else if (down > 0) begin
      down <= down - 1;
    end
  end
  assign core_finished = (down == 1) || man_fin;
  assign core_ans      = stub_ans;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge avm_clk);
    avm_rst   = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    man_fin   = 1'b0;
    @(negedge avm_clk);
    @(negedge avm_clk);
    avm_rst = 1'b0;
  endtask

  task automatic set_ops(input int r, input logic [KW-1:0] m, input logic [KW-1:0] k,
                         input logic [KW-1:0] n);
    req_msg[r*KW +: KW] = m;
    req_key[r*KW +: KW] = k;
    req_n[r*KW +: KW]   = n;
  endtask

  // Raise req_valid[r] and return the cycle index in which it is accepted (-1 if never).
  task automatic wait_accept(input int r, output int t_acc);
    bit got = 0;
    req_valid[r] = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (req_ready[r]) begin
        got   = 1;
        t_acc = cyc;
      end else begin
        @(negedge avm_clk);
      end
    end
  endtask

  typedef struct {
    int            r;
    logic [KW-1:0] m, k, n;
    int            lat;
    logic [KW-1:0] d;
    bit            to;
    bit            early;
  } vec_t;

  task automatic run_job(input int idx, input vec_t v);
    int t_acc, v_cyc, ab_n, ab_cyc, exp_v;
    bit got;
    string nm;
    nm       = $sformatf("vec%0d", idx);
    rand_lat = 0;
    stub_lat = v.lat;
    @(negedge avm_clk);
    set_ops(v.r, v.m, v.k, v.n);
    if (v.early) rsp_ready[v.r] = 1'b1;
    wait_accept(v.r, t_acc);
    check({nm, "_accept"}, (t_acc >= 0), 1);
    if (t_acc < 0) begin
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      return;
    end
    @(negedge avm_clk);
    req_valid[v.r] = 1'b0;
    check({nm, "_start"}, core_start, 1);
    check({nm, "_core_msg"}, core_msg, v.m);
    check({nm, "_core_n"}, core_n, v.n);
    check({nm, "_grant_id"}, grant_id, v.r);
    ab_n = 0; ab_cyc = -1; got = 0;
    for (int i = 0; i < 120 && !got; i++) begin
      if (core_abort) begin
        ab_n++;
        ab_cyc = cyc;
      end
      if (rsp_valid != 2'b00) got = 1;
      else @(negedge avm_clk);
    end
    check({nm, "_rsp_seen"}, got, 1);
    v_cyc = cyc;
    exp_v = (v.lat >= 1 && v.lat <= 50) ? t_acc + 2 + v.lat : t_acc + 52;
    check({nm, "_rsp_cycle"}, 64'(v_cyc - t_acc), 64'(exp_v - t_acc));
    check({nm, "_rsp_valid"}, rsp_valid, (v.r == 1) ? 2 : 1);
    check({nm, "_rsp_data"}, rsp_data, v.d);
    check({nm, "_rsp_timeout"}, rsp_timeout, v.to);
    check({nm, "_abort_count"}, ab_n, v.to ? 1 : 0);
    if (v.to) check({nm, "_abort_cycle"}, 64'(ab_cyc - t_acc), 51);
    rsp_ready[v.r] = 1'b1;
    @(negedge avm_clk);
    rsp_ready = 2'b00;
    #1;
    check({nm, "_rsp_drop"}, rsp_valid, 0);
    check({nm, "_idle"}, busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    int       t_acc, n_g, quiet;
    bit       got;
    bit       g[4];
    int       pend[2];
    bit [1:0] clr, hs, hs2;
    bit       m_rr, exp_g, infl, i_r;
    logic [KW-1:0] exp_d;
    int       done;

    tbl[0] = '{0, 16'd5,  16'd3,  16'd33,   10, 16'd26,  1'b0, 1'b0};
    tbl[1] = '{1, 16'd7,  16'd2,  16'd11,    1, 16'd5,   1'b0, 1'b1};
    tbl[2] = '{0, 16'd2,  16'd10, 16'd1000, 49, 16'd24,  1'b0, 1'b0};
    tbl[3] = '{1, 16'd3,  16'd4,  16'd17,   50, 16'd13,  1'b0, 1'b0};
    tbl[4] = '{0, 16'd10, 16'd0,  16'd7,     0, 16'd0,   1'b1, 1'b0};
    tbl[5] = '{1, 16'd4,  16'd13, 16'd497,   5, 16'd445, 1'b0, 1'b0};

    // Reset values
    @(negedge avm_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_start", core_start, 0);
    @(negedge avm_clk);
    avm_rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_req_ready", req_ready, 0);
    check("post_rst_core_n", core_n, 0);
    check("post_rst_grant_id", grant_id, 0);
    check("post_rst_rsp", {rsp_data, rsp_timeout}, 0);

    // Both requesters continuously valid from reset: grants alternate 0,1,0,1
    stub_lat = 2;
    @(negedge avm_clk);
    set_ops(0, 16'd3, 16'd3, 16'd7);
    set_ops(1, 16'd2, 16'd5, 16'd9);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    n_g = 0;
    for (int i = 0; i < 200 && n_g < 4; i++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin
        check("rr_ready_onehot", $onehot(req_ready), 1);
        g[n_g] = req_ready[1];
        n_g++;
      end
      @(negedge avm_clk);
    end
    req_valid = 2'b00;
    check("rr_grant_count", n_g, 4);
    check("rr_grant0", g[0], 0);
    check("rr_grant1", g[1], 1);
    check("rr_grant2", g[2], 0);
    check("rr_grant3", g[3], 1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (!busy) got = 1; else @(negedge avm_clk);
    end
    check("rr_drain", got, 1);
    rsp_ready = 2'b00;

    // core_finished while idle is ignored
    @(negedge avm_clk);
    man_fin = 1'b1;
    @(negedge avm_clk);
    man_fin = 1'b0;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (busy || rsp_valid != 2'b00) quiet++;
      @(negedge avm_clk);
    end
    check("idle_finish_ignored", quiet, 0);

    for (int i = 0; i < 6; i++) run_job(i, tbl[i]);

    // Response held off 20 cycles with requester 0 waiting
    stub_lat = 4;
    @(negedge avm_clk);
    set_ops(1, 16'd3, 16'd7, 16'd11);
    wait_accept(1, t_acc);
    check("hold_accept", (t_acc >= 0), 1);
    @(negedge avm_clk);
    req_valid[1] = 1'b0;
    set_ops(0, 16'd6, 16'd2, 16'd13);
    req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rsp_valid != 2'b00) got = 1; else @(negedge avm_clk);
    end
    check("hold_rsp_seen", got, 1);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("hold_rsp_valid", rsp_valid, 2);
      check("hold_rsp_data", rsp_data, 9);
      check("hold_req_ready", req_ready, 0);
      @(negedge avm_clk);
    end
    rsp_ready[1] = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge avm_clk);
    rsp_ready = 2'b00;
    #1;
    check("hold_release", rsp_valid, 0);

    // Reset in the middle of a run
    stub_lat = 0;
    @(negedge avm_clk);
    set_ops(1, 16'd11, 16'd5, 16'd23);
    wait_accept(1, t_acc);
    check("midrst_accept", (t_acc >= 0), 1);
    for (int i = 0; i < 6; i++) @(negedge avm_clk);
    check("midrst_running", busy, 1);
    avm_rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_start_abort", {core_start, core_abort}, 0);
    check("midrst_core_ops", {core_msg, core_key, core_n}, 0);
    check("midrst_grant_id", grant_id, 0);
    @(negedge avm_clk);
    req_valid = 2'b00;
    avm_rst   = 1'b0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid != 2'b00 || busy) quiet++;
      @(negedge avm_clk);
    end
    check("midrst_no_rsp", quiet, 0);
    run_job(10, tbl[0]);

    // Randomized jobs against a transaction-level model
    do_reset();
    rand_lat = 1;
    m_rr = 1'b1;
    pend[0] = 12; pend[1] = 12;
    clr = 2'b00; infl = 0; i_r = 0; exp_d = '0; done = 0;
    for (int c = 0; c < 4000 && done < 24; c++) begin
      @(negedge avm_clk);
      for (int r = 0; r < 2; r++) if (clr[r]) req_valid[r] = 1'b0;
      clr = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && pend[r] > 0 && $urandom_range(0, 2) == 0) begin
          set_ops(r, KW'($urandom), KW'($urandom), KW'($urandom_range(2, 65535)));
          req_valid[r] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      check("rand_ready_onehot0", $onehot0(req_ready), 1);
      check("rand_valid_onehot0", $onehot0(rsp_valid), 1);
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        exp_g = (req_valid == 2'b11) ? ~m_rr : req_valid[1];
        check("rand_grant", hs[1], exp_g);
        check("rand_single_job", infl, 0);
        infl  = 1;
        i_r   = hs[1];
        exp_d = modexp(req_msg[i_r*KW +: KW], req_key[i_r*KW +: KW], req_n[i_r*KW +: KW]);
        pend[i_r]--;
        clr[i_r] = 1'b1;
      end
      if (rsp_valid != 2'b00) check("rand_rsp_owner", rsp_valid, i_r ? 2 : 1);
      hs2 = rsp_valid & rsp_ready;
      if (hs2 != 2'b00) begin
        check("rand_rsp_data", rsp_data, exp_d);
        check("rand_rsp_timeout", rsp_timeout, 0);
        m_rr = hs2[1];
        infl = 0;
        done++;
      end
    end
    check("rand_jobs_done", done, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
